// File: rtl/guess_display_pkg.sv
// ---------------------------------------------------------------------------
// guess_display_pkg
//   Shared types and constants for the guess display stage.
//   - state_t    : display FSM states (IDLE, WAIT, PLAY, WON)
//   - SEG_LUT    : 16-entry active-low {g,f,e,d,c,b,a} glyph table, 0..F
//   - SEG_BLANK  : all segments off
//   - seg_encode : nibble -> glyph helper
// ---------------------------------------------------------------------------
package guess_display_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no guess evaluated yet
    S_WAIT = 2'd1,  // guess latched, waiting for the game core flags
    S_PLAY = 2'd2,  // at least one over/under result seen
    S_WON  = 2'd3   // equal seen; display frozen, equal LED blinks
  } state_t;

  // Index 0 is the leftmost element thanks to the [0:15] range.
  localparam logic [0:15][6:0] SEG_LUT = {
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/guess_display_hex7seg.sv
// ---------------------------------------------------------------------------
// hex7seg
//   Combinational 4-bit to 7-segment decoder, active-low outputs.
//   Ports:
//     value  in  4  nibble to display
//     blank  in  1  force all segments off
//     seg    out 7  {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module hex7seg
  import guess_display_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      seg = seg_encode(value);
    end
  end

endmodule

// File: rtl/guess_display.sv
// ---------------------------------------------------------------------------
// guess_display
//   Display stage for the number-guessing game. Latches each entered guess,
//   waits FLAG_DELAY cycles for the game core to publish its result flags,
//   then counts the attempt (BCD, saturating) and lights the result LED.
//   Once the guess is correct everything freezes and led_equal blinks.
//
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     enter               raw enter level (rising edge starts a guess)
//     guess[7:0]          current guess value
//     dp_over/under/equal game core result flags
//     hex0, hex1          latched guess, low / high nibble (blank until first)
//     hex2, hex3          attempt count, BCD ones / tens
//     led_over/led_under  last evaluated result
//     led_equal           won; blinks with half-period BLINK_CYCLES
//   All outputs come straight from registers.
// ---------------------------------------------------------------------------
module guess_display
  import guess_display_pkg::*;
#(
  parameter int FLAG_DELAY   = 2,         // 1..15
  parameter int BLINK_CYCLES = 25000000,  // >= 1
  parameter int MAX_ATTEMPTS = 99         // <= 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic [7:0] guess,
  input  logic       dp_over,
  input  logic       dp_under,
  input  logic       dp_equal,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       led_over,
  output logic       led_under,
  output logic       led_equal
);

  // The counter is loaded with FLAG_DELAY-1 on the edge cycle and the flags
  // are sampled when it reads zero, i.e. exactly FLAG_DELAY cycles after
  // the edge was detected.
  localparam logic [3:0] DELAY_LOAD = 4'(FLAG_DELAY - 1);

  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  localparam logic [3:0] MAX_TENS = 4'(MAX_ATTEMPTS / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_ATTEMPTS % 10);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic               enter_q_reg;
  state_t             state_reg,     state_next;
  state_t             prev_reg,      prev_next;      // state to resume on bad flags
  logic [3:0]         delay_reg,     delay_next;
  logic [7:0]         guess_reg,     guess_next;
  logic               shown_reg,     shown_next;     // a guess has been latched
  logic [3:0]         ones_reg,      ones_next;
  logic [3:0]         tens_reg,      tens_next;
  logic               led_over_reg,  led_over_next;
  logic               led_under_reg, led_under_next;
  logic               led_equal_reg, led_equal_next;
  logic [BLINK_W-1:0] blink_cnt_reg, blink_cnt_next;
  logic [6:0]         hex_reg [4];

  logic enter_edge;
  logic flags_one_hot;
  logic at_max;

  assign enter_edge    = enter & ~enter_q_reg;
  assign flags_one_hot = $onehot({dp_over, dp_under, dp_equal});
  assign at_max        = (tens_reg == MAX_TENS) && (ones_reg == MAX_ONES);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    prev_next      = prev_reg;
    delay_next     = delay_reg;
    guess_next     = guess_reg;
    shown_next     = shown_reg;
    ones_next      = ones_reg;
    tens_next      = tens_reg;
    led_over_next  = led_over_reg;
    led_under_next = led_under_reg;
    led_equal_next = led_equal_reg;
    blink_cnt_next = blink_cnt_reg;

    case (state_reg)
      S_IDLE, S_PLAY: begin
        if (enter_edge) begin
          guess_next = guess;
          shown_next = 1'b1;
          delay_next = DELAY_LOAD;
          prev_next  = state_reg;
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        // Enter edges are deliberately not looked at here.
        if (delay_reg != 4'd0) begin
          delay_next = delay_reg - 4'd1;
        end else if (flags_one_hot) begin
          if (!at_max) begin
            if (ones_reg == 4'd9) begin
              ones_next = 4'd0;
              tens_next = tens_reg + 4'd1;
            end else begin
              ones_next = ones_reg + 4'd1;
            end
          end
          led_over_next  = dp_over;
          led_under_next = dp_under;
          led_equal_next = dp_equal;
          blink_cnt_next = '0;
          state_next     = dp_equal ? S_WON : S_PLAY;
        end else begin
          // Ambiguous result: nothing counted, LEDs untouched.
          state_next = prev_reg;
        end
      end

      S_WON: begin
        if (blink_cnt_reg == BLINK_LAST) begin
          blink_cnt_next = '0;
          led_equal_next = ~led_equal_reg;
        end else begin
          blink_cnt_next = blink_cnt_reg + BLINK_W'(1);
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      enter_q_reg   <= 1'b0;
      state_reg     <= S_IDLE;
      prev_reg      <= S_IDLE;
      delay_reg     <= 4'd0;
      guess_reg     <= 8'h00;
      shown_reg     <= 1'b0;
      ones_reg      <= 4'd0;
      tens_reg      <= 4'd0;
      led_over_reg  <= 1'b0;
      led_under_reg <= 1'b0;
      led_equal_reg <= 1'b0;
      blink_cnt_reg <= '0;
    end else begin
      enter_q_reg   <= enter;
      state_reg     <= state_next;
      prev_reg      <= prev_next;
      delay_reg     <= delay_next;
      guess_reg     <= guess_next;
      shown_reg     <= shown_next;
      ones_reg      <= ones_next;
      tens_reg      <= tens_next;
      led_over_reg  <= led_over_next;
      led_under_reg <= led_under_next;
      led_equal_reg <= led_equal_next;
      blink_cnt_reg <= blink_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Segment outputs: decode the next values and register the glyphs so the
  // pins are flop-driven while still showing a new guess one cycle after
  // its edge.
  // -------------------------------------------------------------------------
  logic [3:0] digit_next [4];
  logic       blank_next [4];
  logic [6:0] seg_next   [4];

  assign digit_next[0] = guess_next[3:0];
  assign digit_next[1] = guess_next[7:4];
  assign digit_next[2] = ones_next;
  assign digit_next[3] = tens_next;
  assign blank_next[0] = ~shown_next;
  assign blank_next[1] = ~shown_next;
  assign blank_next[2] = 1'b0;
  assign blank_next[3] = 1'b0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      // Guess digits reset blank, attempt digits reset to "0".
      localparam logic [6:0] RESET_GLYPH = (gi < 2) ? SEG_BLANK : SEG_LUT[0];

      hex7seg u_dec (
        .value (digit_next[gi]),
        .blank (blank_next[gi]),
        .seg   (seg_next[gi])
      );

      always_ff @(posedge clk) begin
        if (reset) begin
          hex_reg[gi] <= RESET_GLYPH;
        end else begin
          hex_reg[gi] <= seg_next[gi];
        end
      end
    end
  endgenerate

  assign hex0      = hex_reg[0];
  assign hex1      = hex_reg[1];
  assign hex2      = hex_reg[2];
  assign hex3      = hex_reg[3];
  assign led_over  = led_over_reg;
  assign led_under = led_under_reg;
  assign led_equal = led_equal_reg;

endmodule

// File: tb/tb_guess_display.sv
// ---------------------------------------------------------------------------
// tb_guess_display
//   Self-checking bench for guess_display (FLAG_DELAY=2, BLINK_CYCLES=4).
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_guess_display;

  localparam int FLAG_DELAY   = 2;
  localparam int BLINK_CYCLES = 4;
  localparam int MAX_ATTEMPTS = 99;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter;
  logic [7:0] guess;
  logic       dp_over, dp_under, dp_equal;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       led_over, led_under, led_equal;

  guess_display #(
    .FLAG_DELAY   (FLAG_DELAY),
    .BLINK_CYCLES (BLINK_CYCLES),
    .MAX_ATTEMPTS (MAX_ATTEMPTS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enter     (enter),
    .guess     (guess),
    .dp_over   (dp_over),
    .dp_under  (dp_under),
    .dp_equal  (dp_equal),
    .hex0      (hex0),
    .hex1      (hex1),
    .hex2      (hex2),
    .hex3      (hex3),
    .led_over  (led_over),
    .led_under (led_under),
    .led_equal (led_equal)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Glyph table transcribed from the segment encoding list.
  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // ---------------- behavioural reference model (per transaction) ---------
  int         m_att;
  logic [7:0] m_guess;
  bit         m_shown, m_won, m_over, m_under;

  function automatic void model_reset();
    m_att = 0; m_guess = 8'h00; m_shown = 0; m_won = 0; m_over = 0; m_under = 0;
  endfunction

  // f = {over, under, equal}
  function automatic void model_txn(input logic [7:0] g, input logic [2:0] f);
    int n;
    if (m_won) return;
    m_guess = g;
    m_shown = 1;
    n = int'(f[2]) + int'(f[1]) + int'(f[0]);
    if (n == 1) begin
      if (m_att < MAX_ATTEMPTS) m_att = m_att + 1;
      m_over  = f[2];
      m_under = f[1];
      m_won   = f[0];
    end
  endfunction

  function automatic logic [6:0] exp_digit(input int idx);
    int v;
    case (idx)
      0: v = int'(m_guess[3:0]);
      1: v = int'(m_guess[7:4]);
      2: v = m_att % 10;
      default: v = m_att / 10;
    endcase
    if (idx < 2 && !m_shown) return 7'h7F;
    return seg_tab[v];
  endfunction

  // ---------------- checking helpers -------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " hex0"}, 32'(hex0), 32'(exp_digit(0)));
    chk({tag, " hex1"}, 32'(hex1), 32'(exp_digit(1)));
    chk({tag, " hex2"}, 32'(hex2), 32'(exp_digit(2)));
    chk({tag, " hex3"}, 32'(hex3), 32'(exp_digit(3)));
    chk({tag, " led_over"}, 32'(led_over), 32'(m_over));
    chk({tag, " led_under"}, 32'(led_under), 32'(m_under));
    if (!m_won) chk({tag, " led_equal"}, 32'(led_equal), 32'd0);
  endtask

  // ---------------- stimulus helpers -------------------------------------
  task automatic do_reset();
    reset = 1'b1; enter = 1'b0; guess = 8'h00;
    dp_over = 1'b0; dp_under = 1'b0; dp_equal = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
  endtask

  // Called at a falling edge; returns at a falling edge with outputs settled.
  task automatic guess_txn(input logic [7:0] g, input logic [2:0] f, input int hold);
    guess = g;
    {dp_over, dp_under, dp_equal} = f;
    enter = 1'b1;
    repeat (hold) @(negedge clk);
    enter = 1'b0;
    repeat (FLAG_DELAY + 2) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] g;
    logic [2:0] f;
    int         hold;
    logic [6:0] e_hex0, e_hex1, e_hex2, e_hex3;
    logic       e_over, e_under;
  } vec_t;

  vec_t vecs [4];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- table of sequential game vectors --------------------
    vecs[0] = '{8'hC0, 3'b100, 2, 7'h40, 7'h46, 7'h79, 7'h40, 1'b1, 1'b0};
    vecs[1] = '{8'h25, 3'b010, 1, 7'h12, 7'h24, 7'h24, 7'h40, 1'b0, 1'b1};
    vecs[2] = '{8'h2F, 3'b001, 1, 7'h0E, 7'h24, 7'h30, 7'h40, 1'b0, 1'b0};
    vecs[3] = '{8'h2A, 3'b100, 1, 7'h0E, 7'h24, 7'h30, 7'h40, 1'b0, 1'b0};

    // ---------------- reset values ----------------------------------------
    do_reset();
    chk("reset hex0", 32'(hex0), 32'h7F);
    chk("reset hex1", 32'(hex1), 32'h7F);
    chk("reset hex2", 32'(hex2), 32'h40);
    chk("reset hex3", 32'(hex3), 32'h40);
    chk("reset leds", 32'({led_over, led_under, led_equal}), 32'd0);
    $display("txn reset: hex=%h %h %h %h", hex3, hex2, hex1, hex0);

    // ---------------- table-driven game -----------------------------------
    for (int i = 0; i < 4; i++) begin
      guess_txn(vecs[i].g, vecs[i].f, vecs[i].hold);
      $display("txn vec%0d guess=%h flags=%b -> hex=%h %h %h %h leds=%b%b%b",
               i, vecs[i].g, vecs[i].f, hex3, hex2, hex1, hex0,
               led_over, led_under, led_equal);
      chk($sformatf("vec%0d hex0", i), 32'(hex0), 32'(vecs[i].e_hex0));
      chk($sformatf("vec%0d hex1", i), 32'(hex1), 32'(vecs[i].e_hex1));
      chk($sformatf("vec%0d hex2", i), 32'(hex2), 32'(vecs[i].e_hex2));
      chk($sformatf("vec%0d hex3", i), 32'(hex3), 32'(vecs[i].e_hex3));
      chk($sformatf("vec%0d led_over", i), 32'(led_over), 32'(vecs[i].e_over));
      chk($sformatf("vec%0d led_under", i), 32'(led_under), 32'(vecs[i].e_under));
    end

    // ---------------- latency and blink after a win ------------------------
    do_reset();
    @(negedge clk);
    guess = 8'h5A; dp_equal = 1'b1; enter = 1'b1;
    @(negedge clk);                         // one cycle after the edge
    enter = 1'b0;
    chk("latch hex0", 32'(hex0), 32'h08);
    chk("latch hex1", 32'(hex1), 32'h12);
    chk("latch hex2 early", 32'(hex2), 32'h40);
    @(negedge clk);                         // sample cycle not yet visible
    chk("pre-sample hex2", 32'(hex2), 32'h40);
    chk("pre-sample led_equal", 32'(led_equal), 32'd0);
    @(negedge clk);                         // sample visible
    chk("post-sample hex2", 32'(hex2), 32'h79);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("blink cycle %0d", i), 32'(led_equal),
          32'(((i / BLINK_CYCLES) % 2) == 0));
      @(negedge clk);
    end
    $display("txn win-blink: hex2=%h led_equal=%b", hex2, led_equal);

    // ---------------- reset during WAIT -----------------------------------
    do_reset();
    guess = 8'h77; dp_over = 1'b1; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (FLAG_DELAY + 3) @(negedge clk);
    model_reset();
    check_model("midwait reset");
    $display("txn midwait-reset: hex=%h %h %h %h", hex3, hex2, hex1, hex0);

    // ---------------- second edge inside WAIT is ignored ------------------
    do_reset();
    guess = 8'h11; dp_over = 1'b1; enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    guess = 8'h33; enter = 1'b1;            // new edge lands while still waiting
    repeat (2) @(negedge clk);
    enter = 1'b0;
    repeat (FLAG_DELAY + 3) @(negedge clk);
    model_txn(8'h11, 3'b100);
    check_model("wait-edge");
    $display("txn wait-edge: hex=%h %h %h %h", hex3, hex2, hex1, hex0);

    // ---------------- randomized play vs model ----------------------------
    do_reset();
    for (int i = 0; i < 60; i++) begin
      logic [7:0] g;
      logic [2:0] f;
      int         sel;
      g   = 8'($urandom);
      sel = int'($urandom_range(0, 19));
      if (sel < 8)       f = 3'b100;
      else if (sel < 16) f = 3'b010;
      else if (sel < 19) f = 3'($urandom_range(0, 7)) & 3'b110;  // 000 / 110 / 100 / 010
      else               f = 3'b001;
      if (f == 3'b000 && sel == 18) f = 3'b111;
      guess_txn(g, f, int'($urandom_range(1, 3)));
      model_txn(g, f);
      $display("txn rand%0d guess=%h flags=%b att=%0d won=%0d hex=%h %h %h %h",
               i, g, f, m_att, m_won, hex3, hex2, hex1, hex0);
      check_model($sformatf("rand%0d", i));
    end

    // ---------------- saturation at 99 ------------------------------------
    do_reset();
    for (int i = 1; i <= 101; i++) begin
      guess_txn(8'(i), 3'b100, 1);
      model_txn(8'(i), 3'b100);
      if (i >= 98) begin
        $display("txn sat%0d: hex3=%h hex2=%h", i, hex3, hex2);
        check_model($sformatf("sat%0d", i));
      end
    end
    chk("sat tens", 32'(hex3), 32'h10);
    chk("sat ones", 32'(hex2), 32'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
